// File: rtl/clock_enable_controller.sv
// clock_enable_controller
//   Sequences the compute-clock gate enable for bounded or free-running runs.
//   A run is requested with a valid/ready handshake. The block then produces
//   either start_cycles enabled cycles or, when start_cycles is 0, runs until
//   stop. stall_req holds the gate off without ending the run. Loss of lock
//   during a run aborts it into FAULT, which is left with fault_clear.
//
//   Optional feature: define CLOCK_ENABLE_PERF_COUNTER_EN to build the 64-bit
//   lifetime enabled-cycle counter on total_cycles. Without it total_cycles
//   is tied to 0.
//
// Ports
//   control_clock    in   sole clock, rising edge
//   sync_rst_n       in   synchronous active-low reset
//   locked           in   clock-distribution lock indication
//   start_valid      in   run request
//   start_ready      out  request accepted when high with start_valid
//   start_cycles     in   enabled cycles to run, 0 = free-run
//   stop             in   terminate current run
//   stall_req        in   hold compute clock off without ending run
//   fault_clear      in   leave FAULT
//   compute_clock_en out  registered enable to the compute clock gate
//   busy             out  high in RUN
//   done             out  one-cycle pulse at run end
//   fault            out  high in FAULT
//   run_cycles       out  enabled cycles in current or last run
//   total_cycles     out  lifetime enabled cycles (perf counter build only)

module clock_enable_controller #(
    parameter int CYCLE_W = 32
) (
    input  logic               control_clock,
    input  logic               sync_rst_n,
    input  logic               locked,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [CYCLE_W-1:0] start_cycles,
    input  logic               stop,
    input  logic               stall_req,
    input  logic               fault_clear,
    output logic               compute_clock_en,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [CYCLE_W-1:0] run_cycles,
    output logic [63:0]        total_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t             state;
    logic [CYCLE_W-1:0] remaining;
    logic               bounded;
    logic               finish;

    // The last enabled cycle of a bounded run is the one where the
    // remaining count is about to reach zero.
    assign finish = bounded & compute_clock_en & (remaining == CYCLE_W'(1));

    // Gated by reset so the handshake is closed while reset is asserted.
    assign start_ready = sync_rst_n & locked & (state == IDLE);

    always_ff @(posedge control_clock) begin
        if (!sync_rst_n) begin
            state            <= IDLE;
            remaining        <= '0;
            bounded          <= 1'b0;
            run_cycles       <= '0;
            compute_clock_en <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        state            <= RUN;
                        remaining        <= start_cycles;
                        bounded          <= |start_cycles;
                        run_cycles       <= '0;
                        compute_clock_en <= !stall_req;
                        busy             <= 1'b1;
                    end
                end

                RUN: begin
                    // The cycle ending at this edge was enabled: count it,
                    // even if this same edge aborts or ends the run.
                    if (compute_clock_en) begin
                        run_cycles <= run_cycles + CYCLE_W'(1);
                        if (bounded)
                            remaining <= remaining - CYCLE_W'(1);
                    end

                    if (!locked) begin
                        state            <= FAULT;
                        compute_clock_en <= 1'b0;
                        busy             <= 1'b0;
                        fault            <= 1'b1;
                    end else if (finish || stop) begin
                        // Simultaneous stop and finish collapse into one DONE.
                        state            <= DONE;
                        compute_clock_en <= 1'b0;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                    end else begin
                        compute_clock_en <= !stall_req;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                FAULT: begin
                    if (fault_clear && locked) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end

                default: begin
                    state            <= IDLE;
                    compute_clock_en <= 1'b0;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                    fault            <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_ENABLE_PERF_COUNTER_EN
    logic [63:0] total_q;

    always_ff @(posedge control_clock) begin
        if (!sync_rst_n)
            total_q <= '0;
        else if (compute_clock_en)
            total_q <= total_q + 64'd1;
    end

    assign total_cycles = total_q;
`else
    assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_clock_enable_controller.sv
// Directed testbench for clock_enable_controller.
module tb_clock_enable_controller;

    localparam int CYCLE_W = 32;
`ifdef CLOCK_ENABLE_PERF_COUNTER_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               control_clock = 1'b0;
    logic               sync_rst_n;
    logic               locked;
    logic               start_valid;
    logic               start_ready;
    logic [CYCLE_W-1:0] start_cycles;
    logic               stop;
    logic               stall_req;
    logic               fault_clear;
    logic               compute_clock_en;
    logic               busy;
    logic               done;
    logic               fault;
    logic [CYCLE_W-1:0] run_cycles;
    logic [63:0]        total_cycles;

    int checks = 0;
    int errors = 0;

    clock_enable_controller #(.CYCLE_W(CYCLE_W)) dut (
        .control_clock    (control_clock),
        .sync_rst_n       (sync_rst_n),
        .locked           (locked),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .start_cycles     (start_cycles),
        .stop             (stop),
        .stall_req        (stall_req),
        .fault_clear      (fault_clear),
        .compute_clock_en (compute_clock_en),
        .busy             (busy),
        .done             (done),
        .fault            (fault),
        .run_cycles       (run_cycles),
        .total_cycles     (total_cycles)
    );

    always #5 control_clock = ~control_clock;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge control_clock);
        #1;
    endtask

    task automatic accept(input logic [CYCLE_W-1:0] n);
        start_cycles = n;
        start_valid  = 1'b1;
        step();
        start_valid  = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst_n = 1'b0; locked = 1'b1; start_valid = 1'b0; start_cycles = '0;
        stop = 1'b0; stall_req = 1'b0; fault_clear = 1'b0;
        step(); step();
        checks++; if (compute_clock_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", compute_clock_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
        checks++; if (run_cycles !== '0) begin errors++; $display("FAIL rst_run_cycles got %0d want 0", run_cycles); end
        checks++; if (total_cycles !== 64'd0) begin errors++; $display("FAIL rst_total got %0d want 0", total_cycles); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", start_ready); end
        sync_rst_n = 1'b1;
        step();
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", start_ready); end
    endtask

    task automatic test_bounded();
        accept(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b_busy got %b want 1", busy); end
        checks++; if (compute_clock_en !== 1'b1) begin errors++; $display("FAIL b_en0 got %b want 1", compute_clock_en); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (compute_clock_en !== 1'b1 || run_cycles !== CYCLE_W'(i)) begin
                errors++; $display("FAIL b_en%0d got en=%b rc=%0d want en=1 rc=%0d", i, compute_clock_en, run_cycles, i);
            end
        end
        step();
        checks++; if (compute_clock_en !== 1'b0) begin errors++; $display("FAIL b_en_end got %b want 0", compute_clock_en); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b_done got %b want 1", done); end
        checks++; if (run_cycles !== CYCLE_W'(5)) begin errors++; $display("FAIL b_run_cycles got %0d want 5", run_cycles); end
        checks++; if (total_cycles !== (PERF ? 64'd5 : 64'd0)) begin errors++; $display("FAIL b_total got %0d want %0d", total_cycles, PERF ? 5 : 0); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_done_pulse got %b want 0", done); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL b_ready got %b want 1", start_ready); end
        checks++; if (run_cycles !== CYCLE_W'(5)) begin errors++; $display("FAIL b_hold got %0d want 5", run_cycles); end
    endtask

    task automatic test_stall();
        logic exp_en;
        accept(10);
        // Enabled cycles 0..3, stall raised during 3..5 -> gate low 4..6,
        // enabled again 7..12, done observed at 13.
        for (int c = 0; c <= 13; c++) begin
            exp_en = (c <= 3) || (c >= 7 && c <= 12);
            checks++; if (compute_clock_en !== exp_en) begin errors++; $display("FAIL s_en_c%0d got %b want %b", c, compute_clock_en, exp_en); end
            checks++; if (done !== (c == 13)) begin errors++; $display("FAIL s_done_c%0d got %b want %b", c, done, c == 13); end
            stall_req = (c >= 3 && c <= 5);
            if (c < 13) step();
        end
        checks++; if (run_cycles !== CYCLE_W'(10)) begin errors++; $display("FAIL s_run_cycles got %0d want 10", run_cycles); end
        stall_req = 1'b0;
        step();
    endtask

    task automatic test_stop();
        int ndone;
        accept(0);
        for (int c = 0; c <= 19; c++) begin
            checks++; if (compute_clock_en !== 1'b1) begin errors++; $display("FAIL f_en_c%0d got %b want 1", c, compute_clock_en); end
            if (c == 19) stop = 1'b1;
            step();
        end
        checks++; if (compute_clock_en !== 1'b0) begin errors++; $display("FAIL f_en_stop got %b want 0", compute_clock_en); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL f_done got %b want 1", done); end
        checks++; if (run_cycles !== CYCLE_W'(20)) begin errors++; $display("FAIL f_run_cycles got %0d want 20", run_cycles); end
        stop = 1'b0;
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL f_done_pulse got %b want 0", done); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL f_ready got %b want 1", start_ready); end

        // Stop coincident with the last bounded cycle, then held through
        // DONE and IDLE where it must have no effect.
        accept(3);
        step(); step();
        stop = 1'b1;
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sf_done got %b want 1", done); end
        checks++; if (run_cycles !== CYCLE_W'(3)) begin errors++; $display("FAIL sf_run_cycles got %0d want 3", run_cycles); end
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL sf_extra_done got %0d want 0", ndone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sf_busy got %b want 0", busy); end
        stop = 1'b0;
    endtask

    task automatic test_fault();
        accept(0);
        step(); step();
        locked = 1'b0;
        step();
        checks++; if (compute_clock_en !== 1'b0) begin errors++; $display("FAIL x_en got %b want 0", compute_clock_en); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL x_fault got %b want 1", fault); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL x_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL x_busy got %b want 0", busy); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL x_ready got %b want 0", start_ready); end
        checks++; if (run_cycles !== CYCLE_W'(3)) begin errors++; $display("FAIL x_run_cycles got %0d want 3", run_cycles); end
        fault_clear = 1'b1;
        step();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL x_hold_unlocked got %b want 1", fault); end
        locked = 1'b1;
        step();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL x_clear got %b want 0", fault); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL x_ready_clear got %b want 1", start_ready); end
        fault_clear = 1'b0;
    endtask

    task automatic test_locked_idle();
        locked = 1'b0;
        #1;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL li_ready got %b want 0", start_ready); end
        start_cycles = 4; start_valid = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL li_busy got %b want 0", busy); end
        start_valid = 1'b0;
        locked = 1'b1;
        step();
    endtask

    task automatic test_reset_midrun();
        accept(100);
        repeat (10) step();
        sync_rst_n = 1'b0;
        step();
        checks++; if ({compute_clock_en, busy, done, fault} !== 4'b0) begin
            errors++; $display("FAIL mr_flags got %b want 0000", {compute_clock_en, busy, done, fault});
        end
        checks++; if (run_cycles !== '0) begin errors++; $display("FAIL mr_run_cycles got %0d want 0", run_cycles); end
        checks++; if (total_cycles !== 64'd0) begin errors++; $display("FAIL mr_total got %0d want 0", total_cycles); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL mr_ready got %b want 0", start_ready); end
        sync_rst_n = 1'b1;
        step();
    endtask

    task automatic run_to_done(input int n);
        int waited;
        accept(CYCLE_W'(n));
        waited = 0;
        while (done !== 1'b1 && waited < n + 10) begin
            step();
            waited++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run%0d_timeout got done=%b want 1", n, done); end
        step();
    endtask

    task automatic test_perf();
        run_to_done(5);
        run_to_done(7);
        checks++; if (total_cycles !== (PERF ? 64'd12 : 64'd0)) begin
            errors++; $display("FAIL perf_total got %0d want %0d", total_cycles, PERF ? 12 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_bounded();
        test_stall();
        test_stop();
        test_fault();
        test_locked_idle();
        test_reset_midrun();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
